// File: rtl/vec_mem_pkg.sv
// Shared constants and types for the vector load/store sequencer and its
// data-memory port.
package vec_mem_pkg;

  localparam int ADDR_W     = 17;
  localparam int LANES      = 6;
  localparam int LANE_W     = 8;
  localparam int MAX_BURST  = 4;
  localparam int DMEM_WORDS = 10927;
  localparam int IDX_W      = $clog2(MAX_BURST);
  localparam int LEN_W      = 3;

  // Word-index limit sized to the word-address field for a clean compare
  localparam logic [ADDR_W-3:0] DMEM_LIMIT = (ADDR_W-2)'(DMEM_WORDS);

  typedef logic [LANES-1:0][LANE_W-1:0] word_t;
  typedef word_t [MAX_BURST-1:0] burst_t;

  typedef enum logic [1:0] {IDLE, XFER, RESP} lsu_state_t;

endpackage

// File: rtl/vec_lsu_if.sv
// Data-memory port: byte address, write strobe, write data and combinational
// read data returned by the memory.
interface vec_lsu_if;
  import vec_mem_pkg::*;

  logic [ADDR_W-1:0] mem_A;
  logic              mem_WE;
  word_t             mem_WD;
  word_t             mem_RD;

  modport master (output mem_A, output mem_WE, output mem_WD, input mem_RD);
  modport slave  (input mem_A, input mem_WE, input mem_WD, output mem_RD);

endinterface

// File: rtl/vec_lsu_agen.sv
// Strided address generator: holds the running address, access index, stride
// and burst length; flags the last access and out-of-range words.
module vec_lsu_agen
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              last,
  output logic              oob
);

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] stride_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [LEN_W-1:0]  len_reg;

  // Word stride becomes a byte step; the sum wraps modulo 2^ADDR_W
  always_comb addr_next = addr_reg + (stride_reg << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      stride_reg <= '0;
      idx_reg    <= '0;
      len_reg    <= '0;
    end else if (load) begin
      addr_reg   <= base_addr;
      stride_reg <= stride;
      len_reg    <= len;
      idx_reg    <= '0;
    end else if (step) begin
      addr_reg   <= addr_next;
      idx_reg    <= idx_reg + 1'b1;
    end
  end

  assign addr = addr_reg;
  assign idx  = idx_reg;
  assign last = (LEN_W'(idx_reg) == len_reg - LEN_W'(1));
  assign oob  = (addr_reg[ADDR_W-1:2] >= DMEM_LIMIT);

endmodule

// File: rtl/vec_lsu.sv
// Vector load/store sequencer: accepts one burst command and issues up to
// MAX_BURST strided word accesses to data memory, one per clock.
module vec_lsu
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  len,
  input  burst_t            wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output burst_t            rdata,
  vec_lsu_if.master         mem
);

  lsu_state_t        state_reg, state_next;
  logic              is_store_reg;
  burst_t            wdata_reg;
  word_t             rdata_reg [MAX_BURST];
  logic              err_reg;

  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic              last;
  logic              oob;
  logic              accept;
  logic              in_xfer;
  logic              capture;

  assign accept  = (state_reg == IDLE) && start;
  assign in_xfer = (state_reg == XFER);
  assign capture = in_xfer && !is_store_reg && !oob;

  vec_lsu_agen u_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (in_xfer && !oob),
    .base_addr (base_addr),
    .stride    (stride),
    .len       (len),
    .addr      (addr),
    .idx       (idx),
    .last      (last),
    .oob       (oob)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    mem.mem_A  = '0;
    mem.mem_WD = '0;
    mem.mem_WE = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (len == '0 || base_addr[1:0] != 2'b00) state_next = RESP;
          else                                      state_next = XFER;
        end
      end
      XFER: begin
        busy      = 1'b1;
        mem.mem_A = addr;
        if (is_store_reg) mem.mem_WD = wdata_reg[idx];
        // Reset gates the strobe so a mid-burst reset edge never writes
        mem.mem_WE = is_store_reg && !oob && !rst;
        if (oob || last) state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_reg <= 1'b0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
    end else if (accept) begin
      is_store_reg <= is_store;
      wdata_reg    <= wdata;
      err_reg      <= (base_addr[1:0] != 2'b00);
    end else if (in_xfer && oob) begin
      err_reg      <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < MAX_BURST; gi++) begin : g_rdata
    always_ff @(posedge clk) begin
      if (rst || accept)                        rdata_reg[gi] <= '0;
      else if (capture && idx == IDX_W'(gi))    rdata_reg[gi] <= mem.mem_RD;
    end
    assign rdata[gi] = rdata_reg[gi];
  end

  assign err = err_reg;

endmodule

// File: tb/tb_vec_lsu.sv
// Scoreboard bench for vec_lsu: per-access and per-response expectations are
// queued when a command is driven and compared as the burst plays out.
module tb_vec_lsu;
  import vec_mem_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              is_store = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [LEN_W-1:0]  len = '0;
  burst_t            wdata = '0;
  logic              busy, done, err;
  burst_t            rdata;

  vec_lsu_if m ();

  vec_lsu dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .stride    (stride),
    .len       (len),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem       (m)
  );

  always #5 clk = ~clk;

  // Memory model with a backdoor preset port
  word_t             mem [0:DMEM_WORDS-1] = '{default: '0};
  logic [ADDR_W-3:0] widx;
  logic              bd_we = 1'b0;
  int                bd_idx = 0;
  word_t             bd_data = '0;

  assign widx = m.mem_A[ADDR_W-1:2];

  always_comb begin
    m.mem_RD = '0;
    if (int'(widx) < DMEM_WORDS) m.mem_RD = mem[widx];
  end

  always @(posedge clk) begin
    if (m.mem_WE && int'(widx) < DMEM_WORDS) mem[widx] <= m.mem_WD;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  typedef struct {
    int     cyc;
    logic   e;
    burst_t rd;
  } resp_t;

  resp_t             exp_resp [$];
  logic [ADDR_W-1:0] exp_a [$];
  logic              exp_we [$];
  word_t             exp_wd [$];
  logic [ADDR_W-1:0] obs_a [$];
  logic              obs_we [$];
  word_t             obs_wd [$];

  int total = 0;
  int bad   = 0;

  localparam word_t W0 = 48'h0A0B0C0D0E0F;

  task automatic preset(input int k, input word_t v);
    bd_we = 1'b1; bd_idx = k; bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic push_acc(input logic [ADDR_W-1:0] a, input logic we, input word_t wd);
    exp_a.push_back(a); exp_we.push_back(we); exp_wd.push_back(wd);
  endtask

  task automatic push_resp(input int c, input logic e, input burst_t rd);
    resp_t r;
    r.cyc = c; r.e = e; r.rd = rd;
    exp_resp.push_back(r);
  endtask

  task automatic issue(input logic st, input logic [ADDR_W-1:0] b,
                       input logic [ADDR_W-1:0] s, input logic [LEN_W-1:0] l,
                       input burst_t wd);
    is_store = st; base_addr = b; stride = s; len = l; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records each access cycle until done; returns the cycle number of done (-1 on timeout)
  task automatic collect(output int cyc, output logic e, output burst_t rd);
    bit seen = 0;
    cyc = -1; e = 1'b0; rd = '0;
    obs_a.delete(); obs_we.delete(); obs_wd.delete();
    for (int c = 1; c <= 12 && !seen; c++) begin
      if (done) begin
        cyc = c; e = err; rd = rdata; seen = 1;
      end else begin
        obs_a.push_back(m.mem_A); obs_we.push_back(m.mem_WE); obs_wd.push_back(m.mem_WD);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, err}); end
    total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if (m.mem_A !== '0 || m.mem_WE !== 1'b0) begin bad++; $display("FAIL reset_mem_a_we got=%h/%b want=0/0", m.mem_A, m.mem_WE); end
    total++; if (m.mem_WD !== '0) begin bad++; $display("FAIL reset_mem_wd got=%h want=0", m.mem_WD); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_unit();
    int c; logic e; burst_t rd; resp_t r; burst_t want;
    for (int i = 0; i < 4; i++) preset(16 + i, W0 + 48'(i));
    want = '0;
    for (int i = 0; i < 4; i++) begin
      want[i] = W0 + 48'(i);
      push_acc(ADDR_W'(17'h40 + 4 * i), 1'b0, '0);
    end
    push_resp(5, 1'b0, want);
    issue(1'b0, 17'h40, 17'd1, 3'd4, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc) begin bad++; $display("FAIL load_done_cycle got=%0d want=%0d", c, r.cyc); end
    total++; if (e !== r.e) begin bad++; $display("FAIL load_err got=%b want=%b", e, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL load_rdata got=%h want=%h", rd, r.rd); end
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL load_access_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      total++;
      if ({obs_a[0], obs_we[0], obs_wd[0]} !== {exp_a[0], exp_we[0], exp_wd[0]}) begin
        bad++; $display("FAIL load_access got=%h/%b/%h want=%h/%b/%h", obs_a[0], obs_we[0], obs_wd[0], exp_a[0], exp_we[0], exp_wd[0]);
      end
      void'(obs_a.pop_front()); void'(obs_we.pop_front()); void'(obs_wd.pop_front());
      void'(exp_a.pop_front()); void'(exp_we.pop_front()); void'(exp_wd.pop_front());
    end
    exp_a.delete(); exp_we.delete(); exp_wd.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_store_stride2();
    int c; logic e; burst_t rd; resp_t r; burst_t wd;
    preset(16'h41, 48'hDEAD0000BEEF);
    preset(16'h43, 48'hCAFE0000F00D);
    wd = '0;
    wd[0] = 48'h111111111111; wd[1] = 48'h222222222222; wd[2] = 48'h333333333333;
    for (int i = 0; i < 3; i++) push_acc(ADDR_W'(17'h100 + 8 * i), 1'b1, wd[i]);
    push_resp(4, 1'b0, '0);
    issue(1'b1, 17'h100, 17'd2, 3'd3, wd);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL store_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (m.mem_WE !== 1'b0) begin bad++; $display("FAIL store_we_at_done got=%b want=0", m.mem_WE); end
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL store_access_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      total++;
      if ({obs_a[0], obs_we[0], obs_wd[0]} !== {exp_a[0], exp_we[0], exp_wd[0]}) begin
        bad++; $display("FAIL store_access got=%h/%b/%h want=%h/%b/%h", obs_a[0], obs_we[0], obs_wd[0], exp_a[0], exp_we[0], exp_wd[0]);
      end
      void'(obs_a.pop_front()); void'(obs_we.pop_front()); void'(obs_wd.pop_front());
      void'(exp_a.pop_front()); void'(exp_we.pop_front()); void'(exp_wd.pop_front());
    end
    exp_a.delete(); exp_we.delete(); exp_wd.delete();
    @(posedge clk); #1;
    // Read back through the sequencer
    push_resp(4, 1'b0, {48'h0, wd[2], wd[1], wd[0]});
    issue(1'b0, 17'h100, 17'd2, 3'd3, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL readback_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL readback_rdata got=%h want=%h", rd, r.rd); end
    total++; if (mem[16'h41] !== 48'hDEAD0000BEEF) begin bad++; $display("FAIL gap_word_104 got=%h want=deadbeef pattern", mem[16'h41]); end
    total++; if (mem[16'h43] !== 48'hCAFE0000F00D) begin bad++; $display("FAIL gap_word_10c got=%h want=cafef00d pattern", mem[16'h43]); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    int c; logic e; burst_t rd; resp_t r;
    push_resp(1, 1'b1, '0);
    issue(1'b1, 17'h41, 17'd1, 3'd2, {4{48'h777777777777}});
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL misaligned_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (m.mem_WE !== 1'b0 || obs_a.size() != 0) begin bad++; $display("FAIL misaligned_no_access got=%b/%0d want=0/0", m.mem_WE, obs_a.size()); end
    @(posedge clk); #1;
    push_resp(1, 1'b0, '0);
    issue(1'b0, 17'h40, 17'd1, 3'd0, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL len0_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL len0_rdata got=%h want=%h", rd, r.rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    int c; logic e; burst_t rd; resp_t r; burst_t wd;
    wd = '0; wd[0] = 48'hA1A2A3A4A5A6; wd[1] = 48'hB1B2B3B4B5B6;
    push_acc(ADDR_W'(10926 * 4), 1'b1, wd[0]);
    push_acc(ADDR_W'(10927 * 4), 1'b0, wd[1]);
    push_resp(3, 1'b1, '0);
    issue(1'b1, ADDR_W'(10926 * 4), 17'd1, 3'd2, wd);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL oob_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL oob_access_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      total++;
      if ({obs_a[0], obs_we[0], obs_wd[0]} !== {exp_a[0], exp_we[0], exp_wd[0]}) begin
        bad++; $display("FAIL oob_access got=%h/%b/%h want=%h/%b/%h", obs_a[0], obs_we[0], obs_wd[0], exp_a[0], exp_we[0], exp_wd[0]);
      end
      void'(obs_a.pop_front()); void'(obs_we.pop_front()); void'(obs_wd.pop_front());
      void'(exp_a.pop_front()); void'(exp_we.pop_front()); void'(exp_wd.pop_front());
    end
    exp_a.delete(); exp_we.delete(); exp_wd.delete();
    total++; if (mem[10926] !== wd[0]) begin bad++; $display("FAIL oob_first_written got=%h want=%h", mem[10926], wd[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int c; logic e; burst_t rd; resp_t r; burst_t wd; bit done_seen;
    for (int i = 0; i < 4; i++) preset(16'h80 + i, 48'h0000000000AA + 48'(i));
    for (int i = 0; i < 4; i++) wd[i] = 48'h123456789000 + 48'(i);
    issue(1'b1, 17'h200, 17'd1, 3'd4, wd);
    total++; if (m.mem_WE !== 1'b1) begin bad++; $display("FAIL rstmid_first_we got=%b want=1", m.mem_WE); end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    total++; if (m.mem_WE !== 1'b0) begin bad++; $display("FAIL rstmid_we_at_reset got=%b want=0", m.mem_WE); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_after_edge got=%b/%b want=0/0", busy, done); end
    rst = 1'b0;
    done_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (done) done_seen = 1; end
    total++; if (done_seen) begin bad++; $display("FAIL rstmid_no_done got=1 want=0"); end
    total++; if (mem[16'h80] !== wd[0]) begin bad++; $display("FAIL rstmid_access1 got=%h want=%h", mem[16'h80], wd[0]); end
    total++; if (mem[16'h81] !== 48'h0000000000AB) begin bad++; $display("FAIL rstmid_access2_suppressed got=%h want=0000000000ab", mem[16'h81]); end
    push_resp(3, 1'b0, {48'h0, 48'h0, 48'h0000000000AB, wd[0]});
    issue(1'b0, 17'h200, 17'd1, 3'd2, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL rstmid_reload_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL rstmid_reload_rdata got=%h want=%h", rd, r.rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_wrap();
    int c; logic e; burst_t rd; resp_t r;
    push_acc(17'h1FFFC, 1'b0, '0);
    push_resp(2, 1'b1, '0);
    issue(1'b0, 17'h1FFFC, 17'd1, 3'd2, '0);
    // Competing store held on start while busy must be dropped
    is_store = 1'b1; base_addr = 17'h40; stride = 17'd1; len = 3'd1;
    wdata = {4{48'hFFFFFFFFFFFF}}; start = 1'b1;
    collect(c, e, rd);
    start = 1'b0;
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL wrap_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL wrap_access_count got=%0d want=%0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      total++;
      if ({obs_a[0], obs_we[0]} !== {exp_a[0], exp_we[0]}) begin
        bad++; $display("FAIL wrap_access got=%h/%b want=%h/%b", obs_a[0], obs_we[0], exp_a[0], exp_we[0]);
      end
      void'(obs_a.pop_front()); void'(obs_we.pop_front()); void'(obs_wd.pop_front());
      void'(exp_a.pop_front()); void'(exp_we.pop_front()); void'(exp_wd.pop_front());
    end
    exp_a.delete(); exp_we.delete(); exp_wd.delete();
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_ignored got=%b want=0", busy); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (mem[16'h10] !== W0) begin bad++; $display("FAIL busy_store_not_queued got=%h want=%h", mem[16'h10], W0); end
  endtask

  task automatic test_back_to_back();
    int c; logic e; burst_t rd; resp_t r;
    push_resp(4, 1'b0, {48'h0, W0, W0, W0});
    issue(1'b0, 17'h40, 17'd0, 3'd3, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL stride0_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL stride0_rdata got=%h want=%h", rd, r.rd); end
    @(posedge clk); #1;
    push_resp(3, 1'b0, {48'h0, 48'h0, W0 + 48'd2, W0 + 48'd1});
    issue(1'b0, 17'h44, 17'd1, 3'd2, '0);
    collect(c, e, rd);
    r = exp_resp.pop_front();
    total++; if (c !== r.cyc || e !== r.e) begin bad++; $display("FAIL b2b_done got=%0d/%b want=%0d/%b", c, e, r.cyc, r.e); end
    total++; if (rd !== r.rd) begin bad++; $display("FAIL b2b_rdata got=%h want=%h", rd, r.rd); end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_load_unit();
    test_store_stride2();
    test_errors();
    test_out_of_range();
    test_reset_mid();
    test_busy_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
